// File: rtl/uart_io_controller.sv
// Bus-mapped sequencer for the byte-wide UART TX/RX handshakes, with an 8-deep FIFO each way.
// Define UART_IRQ_EN to enable the CTRL register and the level interrupt.
module uart_io_controller #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] addr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq,
    output logic [7:0] UART_TXD,
    output logic       TX_EN,
    input  logic       TX_STATUS,
    input  logic [7:0] UART_RXD,
    input  logic       RX_EFF,
    output logic       RX_READ
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_HOLD, TX_WAIT} tx_state_e;
    typedef enum logic {RX_IDLE, RX_ACK} rx_state_e;

    tx_state_e tx_st_q, tx_st_d;
    rx_state_e rx_st_q, rx_st_d;

    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [DEPTH_LOG2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [7:0] txd_q, txd_d, rdata_q, rdata_d;
    logic       tx_en_q, tx_en_d, rx_read_q, rx_read_d, tx_drop_q, tx_drop_d;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic wr_tx, rd_rx, tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] status, ctrl_rd;

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);

    // A write strobe wins over a simultaneous read, so the read side never pops then.
    assign wr_tx   = wr && (addr == 2'd0);
    assign rd_rx   = rd && !wr && (addr == 2'd1);
    assign tx_pop  = (tx_st_q == TX_IDLE) && !tx_empty && TX_STATUS;
    assign tx_push = wr_tx && (!tx_full || tx_pop);
    assign rx_pop  = rd_rx && !rx_empty;
    assign rx_push = (rx_st_q == RX_IDLE) && RX_EFF && (!rx_full || rx_pop);

    assign status = {2'b00, tx_drop_q, (tx_st_q != TX_IDLE), rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        tx_wp_d  = tx_wp_q + DEPTH_LOG2'(tx_push);
        tx_rp_d  = tx_rp_q + DEPTH_LOG2'(tx_pop);
        tx_cnt_d = tx_cnt_q + (DEPTH_LOG2 + 1)'(tx_push) - (DEPTH_LOG2 + 1)'(tx_pop);
        rx_wp_d  = rx_wp_q + DEPTH_LOG2'(rx_push);
        rx_rp_d  = rx_rp_q + DEPTH_LOG2'(rx_pop);
        rx_cnt_d = rx_cnt_q + (DEPTH_LOG2 + 1)'(rx_push) - (DEPTH_LOG2 + 1)'(rx_pop);
    end

    always_comb begin
        tx_drop_d = tx_drop_q;
        if (wr_tx && tx_full && !tx_pop)
            tx_drop_d = 1'b1;
        else if (wr && (addr == 2'd2) && wdata[5])
            tx_drop_d = 1'b0;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            rdata_d = 8'h00;
            if (!wr) begin
                case (addr)
                    2'd1:    rdata_d = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
                    2'd2:    rdata_d = status;
                    2'd3:    rdata_d = ctrl_rd;
                    default: rdata_d = 8'h00;
                endcase
            end
        end
    end

    always_comb begin
        tx_st_d = tx_st_q;
        txd_d   = txd_q;
        tx_en_d = 1'b0;
        case (tx_st_q)
            TX_IDLE: if (tx_pop) begin
                txd_d   = tx_mem[tx_rp_q];
                tx_st_d = TX_START;
            end
            TX_START: begin
                tx_en_d = 1'b1;
                tx_st_d = TX_HOLD;
            end
            // Guard cycle: the transmitter may not have dropped TX_STATUS yet.
            TX_HOLD: tx_st_d = TX_WAIT;
            TX_WAIT: if (TX_STATUS) tx_st_d = TX_IDLE;
            default: tx_st_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_read_d = 1'b0;
        case (rx_st_q)
            RX_IDLE: if (rx_push) begin
                rx_read_d = 1'b1;
                rx_st_d   = RX_ACK;
            end
            RX_ACK:  if (!RX_EFF) rx_st_d = RX_IDLE;
            default: rx_st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= wdata;
        if (rx_push) rx_mem[rx_wp_q] <= UART_RXD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_st_q   <= TX_IDLE;
            rx_st_q   <= RX_IDLE;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            rx_cnt_q  <= '0;
            txd_q     <= 8'h00;
            rdata_q   <= 8'h00;
            tx_en_q   <= 1'b0;
            rx_read_q <= 1'b0;
            tx_drop_q <= 1'b0;
        end else begin
            tx_st_q   <= tx_st_d;
            rx_st_q   <= rx_st_d;
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            rx_cnt_q  <= rx_cnt_d;
            txd_q     <= txd_d;
            rdata_q   <= rdata_d;
            tx_en_q   <= tx_en_d;
            rx_read_q <= rx_read_d;
            tx_drop_q <= tx_drop_d;
        end
    end

`ifdef UART_IRQ_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr && (addr == 2'd3)) ctrl_d = wdata[1:0];
        irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty & (tx_st_q == TX_IDLE));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= 2'b00;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    assign ctrl_rd = {6'b000000, ctrl_q};
    assign irq     = irq_q;
`else
    assign ctrl_rd = 8'h00;
    assign irq     = 1'b0;
`endif

    assign rdata    = rdata_q;
    assign UART_TXD = txd_q;
    assign TX_EN    = tx_en_q;
    assign RX_READ  = rx_read_q;
endmodule

// File: tb/tb_uart_io_controller.sv
// Randomized bench for uart_io_controller: queue-based byte scoreboard plus UART peer models.
module tb_uart_io_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] addr = 2'd0;
    logic       rd = 1'b0, wr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata, UART_TXD;
    logic       irq, TX_EN, RX_READ;
    logic       TX_STATUS = 1'b1;
    logic [7:0] UART_RXD = 8'h00;
    logic       RX_EFF = 1'b0;

    uart_io_controller #(.DEPTH_LOG2(3)) dut (
        .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
        .rdata(rdata), .irq(irq), .UART_TXD(UART_TXD), .TX_EN(TX_EN),
        .TX_STATUS(TX_STATUS), .UART_RXD(UART_RXD), .RX_EFF(RX_EFF), .RX_READ(RX_READ)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    int tx_pulses = 0, rx_reads = 0, last_en_cyc = -1;
    int tx_busy = 0, rx_gap = 0, rx_raise_cyc = 0;
    bit tx_auto = 0, rx_rand = 0, prev_en = 0, rx_room = 0;
    logic [7:0] rx_cur = 8'h00;
    logic [7:0] tx_exp [$];
    logic [7:0] rx_src [$];
    logic [7:0] rx_model [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample outputs just after the edge, then play the UART peers.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (TX_EN) begin
            chk("tx_en_width", 32'(prev_en), 32'd0);
            if (last_en_cyc >= 0) chk("tx_gap_ge4", 32'(cyc - last_en_cyc >= 4), 32'd1);
            last_en_cyc = cyc;
            tx_pulses++;
            chk("tx_pending", 32'(tx_exp.size() > 0), 32'd1);
            if (tx_exp.size() > 0) chk("tx_byte", 32'(UART_TXD), 32'(tx_exp.pop_front()));
        end
        prev_en = TX_EN;
        if (tx_auto) begin
            if (TX_EN) begin
                tx_busy = $urandom_range(0, 3);
                TX_STATUS = (tx_busy == 0);
            end else if (tx_busy > 0) begin
                tx_busy--;
                if (tx_busy == 0) TX_STATUS = 1'b1;
            end
        end
        if (RX_READ) begin
            chk("rx_read_pending", 32'(RX_EFF), 32'd1);
            if (rx_room) chk("rx_read_lat", 32'(cyc - rx_raise_cyc), 32'd1);
            rx_reads++;
            rx_model.push_back(rx_cur);
            RX_EFF = 1'b0;
            rx_gap = rx_rand ? $urandom_range(0, 3) : 0;
        end else if (!RX_EFF) begin
            if (rx_gap > 0) rx_gap--;
            else if (rx_src.size() > 0) begin
                rx_cur = rx_src.pop_front();
                UART_RXD = rx_cur;
                RX_EFF = 1'b1;
                rx_raise_cyc = cyc;
                rx_room = (rx_model.size() < 8);
            end
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        logic [7:0] e;
        bit had;
        had = (a == 2'd1) && (rx_model.size() > 0);
        e = had ? rx_model[0] : 8'h00;
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
        d = rdata;
        if (a == 2'd1) begin
            chk("rxdata", 32'(rdata), 32'(e));
            if (had) void'(rx_model.pop_front());
        end
    endtask

    logic [7:0] d, b;
    int p0, r0, wcnt;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_txen", 32'(TX_EN), 32'd0);
        chk("rst_rxread", 32'(RX_READ), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_txd", 32'(UART_TXD), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        reset = 1'b1;
        tick();
        bus_read(2'd2, d);
        chk("rst_status", 32'(d), 32'h06);

        // Single byte: TX_EN two cycles after the write edge
        tx_exp.push_back(8'h5A);
        p0 = tx_pulses;
        bus_write(2'd0, 8'h5A);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (tx_pulses > p0) begin
                chk("tx_latency", 32'(k), 32'd2);
                break;
            end
        end
        TX_STATUS = 1'b0;
        chk("tx_single_seen", 32'(tx_pulses - p0), 32'd1);
        repeat (10) tick();
        chk("tx_no_second", 32'(tx_pulses - p0), 32'd1);
        TX_STATUS = 1'b1;
        repeat (3) tick();

        // Overflow: 9 writes while the transmitter is busy
        TX_STATUS = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) tx_exp.push_back(8'(i));
            bus_write(2'd0, 8'(i));
        end
        bus_read(2'd2, d);
        chk("ovf_status", 32'(d), 32'h25);
        p0 = tx_pulses;
        tx_auto = 1; TX_STATUS = 1'b1;
        for (int k = 0; k < 150 && tx_pulses < p0 + 8; k++) tick();
        repeat (10) tick();
        chk("ovf_pulses", 32'(tx_pulses - p0), 32'd8);
        bus_read(2'd2, d);
        chk("ovf_status_drained", 32'(d), 32'h26);
        bus_write(2'd2, 8'h20);
        bus_read(2'd2, d);
        chk("drop_cleared", 32'(d), 32'h06);

        // RX fill and backpressure
        r0 = rx_reads;
        for (int i = 0; i < 9; i++) rx_src.push_back(8'hA0 + 8'(i));
        for (int k = 0; k < 80 && rx_reads < r0 + 8; k++) tick();
        repeat (5) tick();
        chk("rx_fill_reads", 32'(rx_reads - r0), 32'd8);
        chk("rx_backpressure", 32'(RX_EFF), 32'd1);
        bus_read(2'd2, d);
        chk("rx_full_status", 32'(d), 32'h0A);
        bus_read(2'd1, d);
        repeat (2) tick();
        chk("rdata_hold", 32'(rdata), 32'hA0);
        chk("rx_late_ack", 32'(rx_reads - r0), 32'd9);
        repeat (8) bus_read(2'd1, d);
        bus_read(2'd2, d);
        chk("rx_empty_status", 32'(d), 32'h06);
        bus_read(2'd1, d);
        bus_read(2'd2, d);
        chk("rx_empty_status_after", 32'(d), 32'h06);

`ifdef UART_IRQ_EN
        bus_write(2'd3, 8'h01);
        bus_read(2'd3, d);
        chk("ctrl_rb", 32'(d), 32'h01);
        rx_src.push_back(8'h33);
        for (int k = 0; k < 10 && !irq; k++) tick();
        chk("irq_set", 32'(irq), 32'd1);
        bus_read(2'd1, d);
        tick();
        chk("irq_clear", 32'(irq), 32'd0);
        bus_write(2'd3, 8'h00);
`else
        bus_write(2'd3, 8'h03);
        bus_read(2'd3, d);
        chk("ctrl_rb_off", 32'(d), 32'h00);
        rx_src.push_back(8'h33);
        repeat (5) tick();
        chk("irq_off", 32'(irq), 32'd0);
        bus_read(2'd1, d);
`endif

        // Random traffic both directions
        rx_rand = 1;
        wcnt = tx_pulses;
        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (rx_src.size() < 2) rx_src.push_back(8'($urandom));
            if (r < 3 && (wcnt - tx_pulses) < 8) begin
                b = 8'($urandom);
                tx_exp.push_back(b);
                wcnt++;
                bus_write(2'd0, b);
            end else if (r < 6) begin
                bus_read(2'd1, d);
            end else if (r == 6 && (wcnt - tx_pulses) < 8) begin
                b = 8'($urandom);
                tx_exp.push_back(b);
                wcnt++;
                addr = 2'd0; wdata = b; wr = 1'b1; rd = 1'b1;
                tick();
                wr = 1'b0; rd = 1'b0;
                chk("rdwr_rdata", 32'(rdata), 32'd0);
            end else begin
                tick();
            end
        end
        for (int k = 0; k < 300; k++) begin
            if (rx_src.size() == 0 && !RX_EFF && rx_model.size() == 0 && tx_exp.size() == 0) break;
            bus_read(2'd1, d);
        end
        chk("rx_drained", 32'(rx_model.size() + rx_src.size()), 32'd0);
        chk("tx_drained", 32'(tx_exp.size()), 32'd0);
        repeat (6) tick();
        bus_read(2'd2, d);
        chk("random_status", 32'(d), 32'h06);

        // Reset mid-transmit with 3 bytes still queued
        tx_auto = 0; rx_rand = 0; TX_STATUS = 1'b0;
        for (int i = 0; i < 4; i++) bus_write(2'd0, 8'hC0 + 8'(i));
        tx_exp.push_back(8'hC0);
        p0 = tx_pulses;
        TX_STATUS = 1'b1;
        for (int k = 0; k < 10 && tx_pulses == p0; k++) tick();
        TX_STATUS = 1'b0;
        chk("pre_reset_pulse", 32'(tx_pulses - p0), 32'd1);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("midrst_txen", 32'(TX_EN), 32'd0);
        chk("midrst_txd", 32'(UART_TXD), 32'd0);
        tx_exp.delete();
        rx_model.delete();
        reset = 1'b1;
        tick();
        chk("post_rst_txen", 32'(TX_EN), 32'd0);
        bus_read(2'd2, d);
        chk("post_rst_status", 32'(d), 32'h06);
        TX_STATUS = 1'b1;
        repeat (12) tick();
        chk("post_rst_no_tx", 32'(tx_pulses - p0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
